// File: rtl/aes_ct_collector.sv
// Ciphertext collector: buffers aes_128 results plus CED tags in a FIFO and streams them byte-serially.
// Optional AES_CT_FAULT_DROP_EN: faulty captures are discarded (counted in overflow_count), out_fault tied 0.
module aes_ct_collector #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [3:0][3:0][7:0]  ciphertext,
   input  logic                  done,
   input  logic                  fault_detected,
   input  logic [3:0]            fault_location,
   output logic [7:0]            out_byte,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  out_fault,
   output logic [3:0]            out_loc,
   output logic                  full,
   output logic [7:0]            overflow_count
);
   localparam int unsigned PW      = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;
   typedef logic [15:0][7:0] entry_t;

   entry_t      r_mem       [DEPTH];
   logic        r_mem_fault [DEPTH];
   logic [3:0]  r_mem_loc   [DEPTH];
   logic [PW:0] r_wr_ptr, r_rd_ptr;
   logic        r_done_q, r_armed;
   logic [7:0]  r_ovf;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [7:0]  r_out_byte;
   logic        r_out_valid, r_out_last, r_out_fault;
   logic [3:0]  r_out_loc;

   entry_t      w_cap_data, w_head, w_nxt_data;
   logic        w_full, w_empty, w_cap, w_drop_fault, w_cap_fault;
   logic        w_push, w_lost, w_more, w_bypass, w_nxt_fault;
   logic [3:0]  w_nxt_loc, w_cnt_nxt;
   logic [PW:0] w_rd_nxt;

   // Stream byte k is ciphertext[3 - k%4][3 - k/4]
   always_comb begin
      w_cap_data = '0;
      for (int unsigned k = 0; k < 16; k++)
         w_cap_data[4'(k)] = ciphertext[2'(3 - (k % 4))][2'(3 - (k / 4))];
   end

`ifdef AES_CT_FAULT_DROP_EN
   assign w_drop_fault = fault_detected;
   assign w_cap_fault  = 1'b0;
`else
   assign w_drop_fault = 1'b0;
   assign w_cap_fault  = fault_detected;
`endif

   assign w_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   // r_armed blocks a done that was already high when reset released
   assign w_cap     = done & ~r_done_q & r_armed;
   assign w_push    = w_cap & ~w_full & ~w_drop_fault;
   assign w_lost    = w_cap & (w_full | w_drop_fault);
   assign w_rd_nxt  = r_rd_ptr + PTR_ONE;
   assign w_more    = (r_wr_ptr != w_rd_nxt) | w_push;
   assign w_cnt_nxt = r_cnt + 4'd1;
   assign w_head    = r_mem[r_rd_ptr[PW-1:0]];

   // Entry written this cycle becomes the next head: forward it so back-to-back streaming has no bubble
   assign w_bypass    = w_push & (r_wr_ptr == w_rd_nxt);
   assign w_nxt_data  = w_bypass ? w_cap_data     : r_mem[w_rd_nxt[PW-1:0]];
   assign w_nxt_fault = w_bypass ? w_cap_fault    : r_mem_fault[w_rd_nxt[PW-1:0]];
   assign w_nxt_loc   = w_bypass ? fault_location : r_mem_loc[w_rd_nxt[PW-1:0]];

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr[PW-1:0]]       <= w_cap_data;
         r_mem_fault[r_wr_ptr[PW-1:0]] <= w_cap_fault;
         r_mem_loc[r_wr_ptr[PW-1:0]]   <= fault_location;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_done_q <= 1'b0;
         r_armed  <= 1'b0;
         r_ovf    <= '0;
      end else begin
         r_done_q <= done;
         r_armed  <= 1'b1;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_lost && r_ovf != 8'hFF)
            r_ovf <= r_ovf + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_rd_ptr    <= '0;
         r_cnt       <= '0;
         r_out_byte  <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_fault <= 1'b0;
         r_out_loc   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_state     <= S_STREAM;
                  r_cnt       <= '0;
                  r_out_valid <= 1'b1;
                  r_out_byte  <= w_head[0];
                  r_out_last  <= 1'b0;
                  r_out_fault <= r_mem_fault[r_rd_ptr[PW-1:0]];
                  r_out_loc   <= r_mem_loc[r_rd_ptr[PW-1:0]];
               end
            end
            S_STREAM: begin
               if (out_ready) begin
                  if (r_cnt == 4'd15) begin
                     r_rd_ptr   <= w_rd_nxt;
                     r_cnt      <= '0;
                     r_out_last <= 1'b0;
                     if (w_more) begin
                        r_out_byte  <= w_nxt_data[0];
                        r_out_fault <= w_nxt_fault;
                        r_out_loc   <= w_nxt_loc;
                     end else begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_byte  <= '0;
                        r_out_fault <= 1'b0;
                        r_out_loc   <= '0;
                     end
                  end else begin
                     r_cnt      <= w_cnt_nxt;
                     r_out_byte <= w_head[w_cnt_nxt];
                     r_out_last <= (r_cnt == 4'd14);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_byte       = r_out_byte;
   assign out_valid      = r_out_valid;
   assign out_last       = r_out_last;
   assign out_fault      = r_out_fault;
   assign out_loc        = r_out_loc;
   assign full           = w_full;
   assign overflow_count = r_ovf;
endmodule

// File: doc/aes_ct_collector.md
# aes_ct_collector

Downstream stage of `aes_128`. Captures each completed 128-bit ciphertext together with its concurrent-error-detection status (`fault_detected`, `fault_location`). Entries are buffered in a small FIFO and streamed out byte-serially over a valid/ready handshake, in the same byte order the fault-injection flow writes ciphertext to its output files. Bursts of encryptions, including fault-injection campaigns, are decoupled from a slow consumer (UART/host link).

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries. Power of two, 2..16.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low. Sampled on `clock`.
- `ciphertext` in [7:0] x [3:0][3:0]: `aes_128` output array, indexed [row][column].
- `done` in 1: `aes_128` completion. May stay high for multiple cycles.
- `fault_detected` in 1: CED flag. Valid while `done` is high.
- `fault_location` in 4: CED stage code. Valid while `done` is high.
- `out_byte` out 8: streamed ciphertext byte.
- `out_valid` out 1: `out_byte` is valid.
- `out_ready` in 1: consumer accepts the byte.
- `out_last` out 1: marks byte 15 of an entry.
- `out_fault` out 1: `fault_detected` tag of the current entry.
- `out_loc` out 4: `fault_location` tag of the current entry.
- `full` out 1: FIFO holds `DEPTH` entries.
- `overflow_count` out 8: count of captures lost because the FIFO was full. Saturates at 255.

## Operation

- Capture event: rising edge of `done`, detected against a registered copy of `done`. A held-high `done` yields exactly one capture.
- On capture, if not full: the write pointer entry latches all 16 bytes, `fault_detected`, and `fault_location` from the same cycle.
- Capture while `full` = 1 in that cycle: the entry is dropped and `overflow_count` increments. This holds even if a pop completes in the same cycle, since `full` is evaluated before the pop.
- Byte order, index k = 0..15: byte k = `ciphertext[3 - k%4][3 - k/4]`. The first byte is [3][3], then [2][3], [1][3], [0][3], [3][2], … and the last byte is [0][0].
- Streamer FSM:
  - IDLE: `out_valid` = 0. Moves to STREAM when the FIFO is non-empty, with byte counter = 0.
  - STREAM: `out_valid` = 1. `out_byte` = head byte[counter]. `out_fault`/`out_loc` = head tags, constant across all 16 bytes.
  - STREAM handshake: a transfer occurs when `out_valid` & `out_ready`, and the counter increments.
  - STREAM, transfer at counter = 15: `out_last` is high on that byte. The entry pops and the counter wraps to 0. If the FIFO is still non-empty after the pop, the FSM stays in STREAM and the next entry's byte 0 is presented the following cycle with no bubble. Otherwise it goes to IDLE.
- Once `out_valid` rises, `out_byte`, `out_last`, `out_fault`, and `out_loc` are held stable until the transfer.
- Pointers are log2(`DEPTH`) bits plus one wrap bit. `full` = pointers equal except the wrap bit. Empty = pointers fully equal.
- Reset (`reset` = 0 at an edge), including mid-stream: pointers, counter, `overflow_count`, and the `done` history register are cleared; FSM goes to IDLE; buffered entries are discarded. A `done` that is high when reset releases counts as a rising edge only if it was low in a prior sampled cycle after release.

## Timing

- Reset values: `out_byte` = 0x00, `out_valid` = 0, `out_last` = 0, `out_fault` = 0, `out_loc` = 0, `full` = 0, `overflow_count` = 0.
- Capture latency: `done` rises at edge N (sampled at N+1). The entry is written at N+1, and `out_valid` = 1 after N+2 when the FIFO was empty.
- Throughput: one byte per cycle with `out_ready` held high, so 16 cycles per entry. Back-to-back entries have 0 idle cycles.
- Simultaneous capture and pop, not full: both take effect, and the occupancy is unchanged.
- `out_ready` high while `out_valid` = 0 is ignored.

## Configuration

- `AES_CT_FAULT_DROP_EN` defined: captures with `fault_detected` = 1 are not enqueued, and `out_fault` is tied to 0. `overflow_count` is shared and also increments, saturating, on each faulty capture dropped this way.
- Not defined: faulty captures are enqueued and streamed with `out_fault`/`out_loc` tags, as specified above.

## Test plan

- FIPS-197 vector: ciphertext array holding 3925841d02dc09fbdc118597196a0b32 (byte [3][3] = 0x39), one `done` pulse, `out_ready` = 1. Required: 16 bytes 39 25 84 1d … 0b 32, `out_last` only on 0x32, `out_valid` asserted 2 cycles after the pulse.
- `done` held high for 10 cycles: exactly one entry streamed (16 bytes), and `overflow_count` stays 0.
- `out_ready` = 0, 6 captures with `DEPTH` = 4: `full` = 1 after the 4th capture, `overflow_count` = 2. Then release `out_ready`: exactly 64 bytes in capture order, no bubbles between entries.
- Fault tag: capture with `fault_detected` = 1, `fault_location` = 0x5. Without the macro, all 16 bytes show `out_fault` = 1, `out_loc` = 5. With `AES_CT_FAULT_DROP_EN`, no bytes are streamed and `overflow_count` = 1.
- Randomly toggled `out_ready`: `out_byte` and tags stay stable while `out_valid` & !`out_ready`, and the byte sequence is identical to the first scenario.
- Reset asserted at byte 7 with 2 entries queued: next cycle `out_valid` = 0 and `full` = 0; a new capture streams from byte 0 of the new data.
